matrix_game_ctrl: RTL
=====================

# matrix_game_ctrl

Parametrised game controller for the memory-matrix game. It sequences a round: start, timed pattern display, guess play, and win/lose. It tracks found tiles and the remaining wrong-guess budget for an N-tile board. It sits between the pattern generator (board source) and the display/HEX logic, replacing the fixed 8-tile guess-counter/checker/rate-divider trio with one generic block.

## Interface
Parameters:
- N_TILES, 8, number of tiles (width of board/guess/found)
- GUESS_W, 4, width of the guess budget
- DISPLAY_CYCLES, 100_000_000, pattern display time in clocks (2 s at 50 MHz); must be ≥1

Ports (reset reset, synchronous, active-low; clock clk):
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  active-high level start/acknowledge button
- board  in  N_TILES  pattern; sampled on round start
- max_guesses  in  GUESS_W  wrong-guess budget; sampled on round start
- guess  in  N_TILES  raw active-high tile buttons (level)
- show_board  out  1  drive board_q to display
- board_q  out  N_TILES  latched pattern of the current round
- found  out  N_TILES  correctly guessed tiles
- guesses_left  out  GUESS_W  remaining wrong guesses
- phase  out  3  current state encoding
- win, lose  out  1  levels, high while in WIN / LOSE
- hit_pulse, miss_pulse  out  1  one-cycle event strobes

## Operation
- States (phase encoding): IDLE=0, START_WAIT=1, DISPLAY=2, PLAY=3, CHECK=4, WIN=5, LOSE=6, END_WAIT=7.
- IDLE:
  - start=1 → START_WAIT.
  - On that transition, latch board→board_q and max_guesses→guesses_left, and clear found.
- START_WAIT: start=0 → DISPLAY. Load the display counter with DISPLAY_CYCLES-1.
- DISPLAY:
  - show_board=1; counter decrements each cycle.
  - When counter==0, go to WIN if board_q==0, else LOSE if guesses_left==0, else PLAY.
- Edge detect:
  - g_prev<=guess every cycle in every state; new = guess & ~g_prev.
  - Buttons held when PLAY is entered never register.
- PLAY:
  - new one-hot → latch pending, go to CHECK.
  - new with ≥2 bits set → ignored; stay in PLAY.
  - new==0 → stay in PLAY.
- CHECK (one cycle):
  - pending & board_q & ~found ≠0 → found|=pending, hit_pulse.
  - pending & found ≠0 (repeat hit) → no change, no pulse.
  - pending & board_q ==0 → guesses_left-=1 (saturating at 0), miss_pulse.
- Next state after CHECK:
  - LOSE if a miss made guesses_left 0.
  - else WIN if updated found==board_q.
  - else PLAY.
- WIN/LOSE: start=1 → END_WAIT. show_board=1 in LOSE (reveal).
- END_WAIT: start=0 → IDLE. found, board_q and guesses_left hold until the next round start.
- Inputs board/max_guesses are ignored outside the IDLE→START_WAIT transition.

## Timing
- All outputs are registered.
- Reset values: phase=IDLE, show_board=0, board_q=0, found=0, guesses_left=0, win=0, lose=0, hit_pulse=0, miss_pulse=0, g_prev=0, counter=0.
- DISPLAY lasts exactly DISPLAY_CYCLES cycles.
- Guess timing:
  - Button rises in cycle k (guess=0 in k-1) → phase=CHECK in k+1.
  - found/guesses_left/pulse and next phase are visible in k+2.
- Edges arriving while in CHECK are lost. Minimum accepted spacing is 2 cycles.
- Pulses are high for exactly one cycle.
- Reset mid-round returns to IDLE next cycle regardless of state.

## Structure
- Package matrix_pkg holds:
  - the state localparams/enum (3-bit) shared with the display block;
  - the default DISPLAY_CYCLES constant.
- One sub-module, display_timer: load/enable/zero-flag down-counter of width $clog2(DISPLAY_CYCLES).
- Edge detect and one-hot check stay inline.

## Test plan
All scenarios use DISPLAY_CYCLES=4 and N_TILES=8.
- Reset, then idle → all outputs 0, phase=0. Press/release start with board=8'h81, max=3 → board_q=8'h81, guesses_left=3, show_board high for exactly 4 cycles, then phase=3.
- In PLAY, press tile 0 then tile 7 (separate edges) → two hit_pulses, found=8'h81, phase=5, win=1.
- Three presses on tile 2 → three miss_pulses, guesses_left 3→2→1→0, phase=6, lose=1, show_board=1.
- Press tile 0 twice, then tiles 1 and 3 in the same cycle → found=8'h01, no pulse for the repeat or the dual press, guesses_left=3.
- Hold tile 0 through DISPLAY into PLAY → no CHECK; a release/re-press registers a hit.
- board=0 → WIN after DISPLAY. max=0 with board≠0 → LOSE after DISPLAY. Assert reset during CHECK → phase=0 next cycle, outputs at reset values.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the memory-matrix game: round state encoding
// (also decoded by the display block) and the default pattern display time.
package matrix_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START_WAIT = 3'd1,
        S_DISPLAY    = 3'd2,
        S_PLAY       = 3'd3,
        S_CHECK      = 3'd4,
        S_WIN        = 3'd5,
        S_LOSE       = 3'd6,
        S_END_WAIT   = 3'd7
    } state_t;

    // 2 s at 50 MHz
    localparam int unsigned DEFAULT_DISPLAY_CYCLES = 100_000_000;

endpackage

// File: rtl/display_timer.sv
// Down-counter timing the pattern display; load presets CYCLES-1 so that
// the zero flag is reached after exactly CYCLES enabled cycles including load.
module display_timer #(
    parameter int unsigned CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic zero
);

    localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= W'(CYCLES - 1);
        end else if (enable && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/matrix_game_ctrl.sv
// Round sequencer for the memory-matrix game: start handshake, timed pattern
// display, edge-detected single-tile guessing, hit/miss scoring and win/lose.
module matrix_game_ctrl
    import matrix_pkg::*;
#(
    parameter int unsigned N_TILES        = 8,
    parameter int unsigned GUESS_W        = 4,
    parameter int unsigned DISPLAY_CYCLES = DEFAULT_DISPLAY_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N_TILES-1:0] board,
    input  logic [GUESS_W-1:0] max_guesses,
    input  logic [N_TILES-1:0] guess,
    output logic               show_board,
    output logic [N_TILES-1:0] board_q,
    output logic [N_TILES-1:0] found,
    output logic [GUESS_W-1:0] guesses_left,
    output logic [2:0]         phase,
    output logic               win,
    output logic               lose,
    output logic               hit_pulse,
    output logic               miss_pulse
);

    state_t             state;
    state_t             next_state;
    logic [N_TILES-1:0] g_prev;
    logic [N_TILES-1:0] pending;
    logic [N_TILES-1:0] new_edge;
    logic               one_hot;
    logic               hit;
    logic               miss;
    logic [N_TILES-1:0] found_upd;
    logic [GUESS_W-1:0] left_upd;
    logic               timer_load;
    logic               timer_en;
    logic               timer_zero;

    display_timer #(
        .CYCLES(DISPLAY_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .enable (timer_en),
        .zero   (timer_zero)
    );

    assign timer_load = (state == S_START_WAIT) && !start;
    assign timer_en   = (state == S_DISPLAY) && !timer_zero;

    assign new_edge = guess & ~g_prev;
    assign one_hot  = (new_edge != '0) && ((new_edge & (new_edge - N_TILES'(1))) == '0);

    // A repeat press on an already found tile is neither a hit nor a miss.
    assign hit       = |(pending & board_q & ~found);
    assign miss      = ~|(pending & board_q);
    assign found_upd = hit ? (found | pending) : found;
    assign left_upd  = (miss && guesses_left != '0) ? guesses_left - GUESS_W'(1) : guesses_left;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:       if (start)  next_state = S_START_WAIT;
            S_START_WAIT: if (!start) next_state = S_DISPLAY;
            S_DISPLAY: begin
                if (timer_zero) begin
                    if (board_q == '0)           next_state = S_WIN;
                    else if (guesses_left == '0) next_state = S_LOSE;
                    else                         next_state = S_PLAY;
                end
            end
            S_PLAY:       if (one_hot) next_state = S_CHECK;
            S_CHECK: begin
                if (miss && left_upd == '0)  next_state = S_LOSE;
                else if (found_upd == board_q) next_state = S_WIN;
                else                         next_state = S_PLAY;
            end
            S_WIN, S_LOSE: if (start)  next_state = S_END_WAIT;
            S_END_WAIT:   if (!start) next_state = S_IDLE;
            default:      next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            g_prev       <= '0;
            pending      <= '0;
            board_q      <= '0;
            found        <= '0;
            guesses_left <= '0;
            show_board   <= 1'b0;
            win          <= 1'b0;
            lose         <= 1'b0;
            hit_pulse    <= 1'b0;
            miss_pulse   <= 1'b0;
        end else begin
            state      <= next_state;
            g_prev     <= guess;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            // Level outputs are decoded from the next state so they align with phase.
            show_board <= (next_state == S_DISPLAY) || (next_state == S_LOSE);
            win        <= (next_state == S_WIN);
            lose       <= (next_state == S_LOSE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        board_q      <= board;
                        guesses_left <= max_guesses;
                        found        <= '0;
                    end
                end
                S_PLAY: begin
                    if (one_hot) pending <= new_edge;
                end
                S_CHECK: begin
                    found        <= found_upd;
                    guesses_left <= left_upd;
                    hit_pulse    <= hit;
                    miss_pulse   <= miss;
                end
                default: ;
            endcase
        end
    end

    assign phase = state;

endmodule
